// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the reset sequencer:
//   - default parameter values
//   - sequencer state enum
//   - counter width helpers
// -----------------------------------------------------------------------------
package reset_sequencer_pkg;

   localparam int DEF_CHANNELS    = 2;
   localparam int DEF_CYCLES      = 20;
   localparam int DEF_STAGGER     = 4;
   localparam int DEF_SW_PULSE    = 8;
   localparam int DEF_CLK_DIV     = 2;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      SWRST   = 2'd3
   } state_t;

   // Sequence count at which the last channel is released.
   function automatic int seq_last(input int cycles, input int channels, input int stagger);
      return cycles - 1 + (channels - 1) * stagger;
   endfunction

   function automatic int seq_width(input int cycles, input int channels, input int stagger);
      return $clog2(cycles + (channels - 1) * stagger + 1);
   endfunction

   function automatic int pulse_width(input int sw_pulse);
      return $clog2(sw_pulse + 1);
   endfunction

   // A divide-by-1 still needs a one-bit counter to keep the logic uniform.
   function automatic int div_width(input int clk_div);
      return (clk_div < 2) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// -----------------------------------------------------------------------------
// reset_sync
// Asynchronous-assert, synchronous-deassert reset synchroniser.
//   clk        in   destination clock
//   rst_n      in   asynchronous active-low reset
//   sync_rst_n out  active-low reset, deasserted STAGES clocks after rst_n rises
// -----------------------------------------------------------------------------
module reset_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic sync_rst_n
);

   logic [STAGES-1:0] chain_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the chain into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], 1'b1};
      end
   end

   assign sync_rst_n = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Staggered multi-channel reset release, software reset pulses and a divided
// clock-enable strobe for processor test harnesses.
//   clk           in   system clock
//   reset_n       in   asynchronous active-low board reset
//   sw_reset_req  in   per-channel software reset request mask (RUN only)
//   hold          in   suppresses clk_en_o while high
//   reset_o       out  active-high per-channel resets
//   clk_en_o      out  one-cycle strobe every CLK_DIV cycles
//   ready_o       out  all channels released, no software reset in progress
//   boot_done_o   out  one-cycle pulse when the power-on sequence completes
// All outputs are registered.
// -----------------------------------------------------------------------------
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int CYCLES      = DEF_CYCLES,
   parameter int STAGGER     = DEF_STAGGER,
   parameter int SW_PULSE    = DEF_SW_PULSE,
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] sw_reset_req,
   input  logic                hold,
   output logic [CHANNELS-1:0] reset_o,
   output logic                clk_en_o,
   output logic                ready_o,
   output logic                boot_done_o
);

   localparam int SEQ_MAX = seq_last(CYCLES, CHANNELS, STAGGER);
   localparam int SEQ_W   = seq_width(CYCLES, CHANNELS, STAGGER);
   localparam int PULSE_W = pulse_width(SW_PULSE);
   localparam int DIV_W   = div_width(CLK_DIV);

   logic                sync_n;
   state_t              state_q, state_d;
   logic [SEQ_W-1:0]    seq_q, seq_d;
   logic [PULSE_W-1:0]  pulse_q, pulse_d;
   logic [CHANNELS-1:0] mask_q, mask_d;
   logic [CHANNELS-1:0] reset_d;
   logic                ready_d, boot_done_d;
   logic [CHANNELS-1:0] chan_hit;
   logic                last_hit;
   logic                pulse_done;
   logic [DIV_W-1:0]    div_q;
   logic                div_hit;

   reset_sync #(
      .STAGES (SYNC_STAGES)
   ) u_reset_sync (
      .clk        (clk),
      .rst_n      (reset_n),
      .sync_rst_n (sync_n)
   );

   // Release points: channel k lets go when the sequence count reaches
   // CYCLES-1 + k*STAGGER. Gated by the synchroniser so a CYCLES=1 build
   // does not release before the board reset has been synchronised.
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         chan_hit[k] = sync_n && (seq_q == SEQ_W'(CYCLES - 1 + k * STAGGER));
      end
   end

   assign last_hit   = sync_n && (seq_q == SEQ_W'(SEQ_MAX));
   assign pulse_done = (pulse_q == PULSE_W'(SW_PULSE));

   // State register, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= BOOT;
         seq_q       <= '0;
         pulse_q     <= '0;
         mask_q      <= '0;
         reset_o     <= '1;
         ready_o     <= 1'b0;
         boot_done_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         pulse_q     <= pulse_d;
         mask_q      <= mask_d;
         reset_o     <= reset_d;
         ready_o     <= ready_d;
         boot_done_o <= boot_done_d;
      end
   end

   // Next-state and counter logic.
   // NOTE: every signal driven here gets a default first, so no path
   // through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      pulse_d = pulse_q;
      mask_d  = mask_q;

      // Sequence counter saturates at the last release point.
      if (sync_n && (state_q == BOOT || state_q == RELEASE) &&
          seq_q != SEQ_W'(SEQ_MAX)) begin
         seq_d = seq_q + SEQ_W'(1);
      end

      case (state_q)
         BOOT: begin
            // STAGGER=0 or a single channel: everything releases at once.
            if (last_hit) begin
               state_d = RUN;
            end else if (chan_hit[0]) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (last_hit) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (|sw_reset_req) begin
               mask_d  = sw_reset_req;
               pulse_d = PULSE_W'(1);
               state_d = SWRST;
            end
         end
         SWRST: begin
            // Counter holds at SW_PULSE after release until the next load.
            if (pulse_done) begin
               state_d = RUN;
            end else begin
               pulse_d = pulse_q + PULSE_W'(1);
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      reset_d     = reset_o;
      ready_d     = ready_o;
      boot_done_d = 1'b0;

      case (state_q)
         BOOT, RELEASE: begin
            reset_d = reset_o & ~chan_hit;
            if (last_hit) begin
               ready_d     = 1'b1;
               boot_done_d = 1'b1;
            end
         end
         RUN: begin
            if (|sw_reset_req) begin
               reset_d = reset_o | sw_reset_req;
               ready_d = 1'b0;
            end
         end
         SWRST: begin
            if (pulse_done) begin
               reset_d = reset_o & ~mask_q;
               ready_d = 1'b1;
            end
         end
         default: reset_d = '1;
      endcase
   end

   // Clock-enable divider: free-running from synchroniser release,
   // independent of the sequencer state. hold only masks the strobe.
   assign div_hit = (div_q == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q    <= '0;
         clk_en_o <= 1'b0;
      end else begin
         if (sync_n) begin
            div_q <= div_hit ? '0 : div_q + DIV_W'(1);
         end
         clk_en_o <= sync_n && div_hit && !hold;
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer. Four instances share clk and reset_n:
//   dut_a  defaults (2 channels, CYCLES=20, STAGGER=4, SW_PULSE=8, CLK_DIV=2)
//   dut_b  CHANNELS=4, CYCLES=5, STAGGER=0
//   dut_c  CLK_DIV=3 with hold toggled
//   dut_d  CLK_DIV=1
// Edge index e counts rising edges from E0 (first edge after reset_n rises).
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

   logic       clk;
   logic       reset_n;
   logic [1:0] sw_req_a;
   logic [3:0] sw_req_b;
   logic [1:0] sw_req_c;
   logic [1:0] sw_req_d;
   logic       hold_a, hold_b, hold_c, hold_d;

   logic [1:0] rst_a;
   logic [3:0] rst_b;
   logic [1:0] rst_c, rst_d;
   logic       en_a, en_b, en_c, en_d;
   logic       rdy_a, rdy_b, rdy_c, rdy_d;
   logic       done_a, done_b, done_c, done_d;

   int n_checks = 0;
   int n_err    = 0;

   reset_sequencer dut_a (
      .clk (clk), .reset_n (reset_n), .sw_reset_req (sw_req_a), .hold (hold_a),
      .reset_o (rst_a), .clk_en_o (en_a), .ready_o (rdy_a), .boot_done_o (done_a)
   );

   reset_sequencer #(
      .CHANNELS (4), .CYCLES (5), .STAGGER (0)
   ) dut_b (
      .clk (clk), .reset_n (reset_n), .sw_reset_req (sw_req_b), .hold (hold_b),
      .reset_o (rst_b), .clk_en_o (en_b), .ready_o (rdy_b), .boot_done_o (done_b)
   );

   reset_sequencer #(
      .CLK_DIV (3)
   ) dut_c (
      .clk (clk), .reset_n (reset_n), .sw_reset_req (sw_req_c), .hold (hold_c),
      .reset_o (rst_c), .clk_en_o (en_c), .ready_o (rdy_c), .boot_done_o (done_c)
   );

   reset_sequencer #(
      .CLK_DIV (1)
   ) dut_d (
      .clk (clk), .reset_n (reset_n), .sw_reset_req (sw_req_d), .hold (hold_d),
      .reset_o (rst_d), .clk_en_o (en_d), .ready_o (rdy_d), .boot_done_o (done_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Values every instance must show while reset_n is low.
   task automatic check_reset_state(input string tag);
      check({tag, " a.reset_o"}, 32'(rst_a), 32'h3);
      check({tag, " a.ready_o"}, 32'(rdy_a), 32'h0);
      check({tag, " a.boot_done_o"}, 32'(done_a), 32'h0);
      check({tag, " a.clk_en_o"}, 32'(en_a), 32'h0);
      check({tag, " b.reset_o"}, 32'(rst_b), 32'hF);
      check({tag, " c.clk_en_o"}, 32'(en_c), 32'h0);
      check({tag, " d.clk_en_o"}, 32'(en_d), 32'h0);
   endtask

   // Runs edges E0..E0+last_e, checking all expected outputs after each edge,
   // then sets up the inputs sampled on the following edge.
   task automatic run_seq(input int last_e);
      logic [1:0] exp_ra;
      logic       exp_rdy_a;
      logic [3:0] exp_rb;
      logic       exp_en_a, exp_en_c, exp_en_d;
      for (int e = 0; e <= last_e; e++) begin
         @(posedge clk);
         #1;
         // dut_a: ch0 at E0+21, ch1 at E0+25; software pulse on ch1 at
         // Ts=E0+31 held for 8 cycles, released at E0+39.
         exp_ra[0] = (e < 21);
         exp_ra[1] = (e < 25) || (e >= 31 && e <= 38);
         exp_rdy_a = (e >= 25) && !(e >= 31 && e <= 38);
         exp_en_a  = (e >= 3) && ((e - 3) % 2 == 0);
         // dut_b: all four released together at E0+6.
         exp_rb    = (e < 6) ? 4'hF : 4'h0;
         // dut_c: strobe every 3rd edge from E0+4, masked while hold sampled high.
         exp_en_c  = (e >= 4) && ((e - 4) % 3 == 0) && !(e >= 10 && e <= 15);
         exp_en_d  = (e >= 2);

         check($sformatf("a.reset_o e=%0d", e), 32'(rst_a), 32'(exp_ra));
         check($sformatf("a.ready_o e=%0d", e), 32'(rdy_a), 32'(exp_rdy_a));
         check($sformatf("a.boot_done_o e=%0d", e), 32'(done_a), 32'(e == 25));
         check($sformatf("a.clk_en_o e=%0d", e), 32'(en_a), 32'(exp_en_a));
         check($sformatf("b.reset_o e=%0d", e), 32'(rst_b), 32'(exp_rb));
         check($sformatf("b.ready_o e=%0d", e), 32'(rdy_b), 32'(e >= 6));
         check($sformatf("b.boot_done_o e=%0d", e), 32'(done_b), 32'(e == 6));
         check($sformatf("c.clk_en_o e=%0d", e), 32'(en_c), 32'(exp_en_c));
         check($sformatf("d.clk_en_o e=%0d", e), 32'(en_d), 32'(exp_en_d));

         // Stimulus for edge e+1.
         case (e)
            22:      sw_req_a = 2'b01;  // sampled in RELEASE: ignored
            30:      sw_req_a = 2'b10;  // sampled in RUN at E0+31
            33:      sw_req_a = 2'b01;  // sampled in SWRST: ignored
            default: sw_req_a = 2'b00;
         endcase
         hold_c = (e + 1 >= 10) && (e + 1 <= 15);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      sw_req_a = '0;
      sw_req_b = '0;
      sw_req_c = '0;
      sw_req_d = '0;
      hold_a   = 1'b0;
      hold_b   = 1'b0;
      hold_c   = 1'b0;
      hold_d   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_state("por");

      // First sequence, interrupted at E0+23 between channel releases.
      @(negedge clk);
      reset_n = 1'b1;
      run_seq(23);

      // Assert reset_n between edges: outputs must return without a clock.
      reset_n = 1'b0;
      #1;
      check_reset_state("async");

      repeat (2) @(posedge clk);
      #1;
      check_reset_state("held");

      // Full sequence relative to the new E0.
      @(negedge clk);
      reset_n = 1'b1;
      run_seq(45);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
